umem_arbiter: RTL

// - Shares one single-port unified memory between the instruction-fetch port (I) and the load/store port (D) of the ARM core.
// - Grants one transaction at a time, sequences the fixed memory read latency, and returns read data to the owner.
// - Sits between the core's PC/Instr and ALUResult/WriteData/ReadData/MemWrite buses and the memory macro.

---
 rtl/umem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/umem_arbiter.sv
// Arbitrates the fetch (I) and load/store (D) ports onto one single-port memory with fixed read latency.
// Optional feature: define ARB_RR_EN for round-robin tie breaking instead of fixed D-over-I priority.
module umem_arbiter #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    if (MEM_LAT < 1) begin : g_lat_check
        $error("umem_arbiter: MEM_LAT must be >= 1");
    end

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;  // 1 = D port owns the outstanding read
    logic          d_wins;

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

`ifdef ARB_RR_EN
    logic rr_last_q, rr_last_d;  // 1 = D was granted last

    assign d_wins    = d_req && (!i_req || !rr_last_q);
    assign rr_last_d = (i_gnt || d_gnt) ? d_gnt : rr_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    assign d_wins = d_req;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    i_gnt   = !d_wins;
                    d_gnt   = d_wins;
                    m_en    = 1'b1;
                    m_we    = d_wins && d_we;
                    m_addr  = d_wins ? d_addr : i_addr;
                    m_wdata = d_wins ? d_wdata : '0;
                    // Stores complete in the grant cycle; only reads occupy the memory.
                    if (!(d_wins && d_we)) begin
                        owner_d = d_wins;
                        if (MEM_LAT == 1) begin
                            state_d = StResp;
                        end else begin
                            cnt_d   = CW'(MEM_LAT - 1);
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                // cnt reaches 0 as RESP is entered, landing rvalid exactly MEM_LAT after grant.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                i_rvalid = !owner_q;
                d_rvalid = owner_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (rst) begin
            i_gnt    = 1'b0;
            d_gnt    = 1'b0;
            i_rvalid = 1'b0;
            d_rvalid = 1'b0;
            m_en     = 1'b0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

endmodule
